// File: rtl/plab3_mem_line_serializer.sv
// plab3_mem_line_serializer
//   Takes a cache line and its per-byte write-enable mask. Emits one beat per
//   word that has at least one enabled byte, in increasing word-offset order.
//   Words whose enable group is all zero are skipped.
//
// Ports
//   clk, reset_n                 clock, async active-low reset
//   sd                           static security-domain label (not used by the logic)
//   in_val / in_rdy              line handshake
//   in_line [c_line_nbits]       line data, word i at [i*p_word_nbits +: p_word_nbits]
//   in_wben [c_wben_nbits]       byte enables, bit j belongs to word j/4
//   out_val / out_rdy            beat handshake
//   out_data [p_word_nbits]      selected word
//   out_offset [p_in_nbits]      word offset of out_data
//   out_wben [4]                 byte enables of that word
//   out_last                     final beat of the line
//
// Build option
//   PLAB3_MEM_SER_BYPASS_EN: accept the next line on the same edge as the last
//   beat, so consecutive lines run with no idle cycle between them.
//
// State | meaning
//   st_idle | waiting for a line; in_rdy high, no beat
//   st_send | presenting word idx of the captured line
module plab3_mem_line_serializer #(
  parameter  int p_in_nbits   = 2,
  parameter  int p_word_nbits = 32,
  localparam int c_line_nbits = p_word_nbits << p_in_nbits,
  localparam int c_wben_nbits = 1 << (p_in_nbits + 2)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    sd,
  input  logic                    in_val,
  output logic                    in_rdy,
  input  logic [c_line_nbits-1:0] in_line,
  input  logic [c_wben_nbits-1:0] in_wben,
  output logic                    out_val,
  input  logic                    out_rdy,
  output logic [p_word_nbits-1:0] out_data,
  output logic [p_in_nbits-1:0]   out_offset,
  output logic [3:0]              out_wben,
  output logic                    out_last
);

  localparam int c_nwords = 1 << p_in_nbits;

  localparam logic [0:0] st_idle = 1'b0;
  localparam logic [0:0] st_send = 1'b1;

  logic [0:0]              state;
  logic [c_line_nbits-1:0] line_reg;
  logic [c_wben_nbits-1:0] mask_reg;
  logic [p_in_nbits-1:0]   idx;

  // The label only travels with the data; nothing here depends on it.
  logic sd_unused;
  assign sd_unused = sd;

  logic [c_nwords-1:0]     grp_reg;
  logic [c_nwords-1:0]     grp_in;
  logic [p_word_nbits-1:0] words [c_nwords];

  always_comb begin
    for (int w = 0; w < c_nwords; w++) begin
      grp_reg[w] = |mask_reg[4*w +: 4];
      grp_in[w]  = |in_wben[4*w +: 4];
      words[w]   = line_reg[w*p_word_nbits +: p_word_nbits];
    end
  end

  // Priority encoders, scanned high to low so the lowest qualifying word wins.
  // next_idx only considers words strictly above idx, so offsets never wrap.
  logic [p_in_nbits-1:0] first_idx;
  logic [p_in_nbits-1:0] next_idx;
  logic                  has_next;

  always_comb begin
    first_idx = '0;
    next_idx  = '0;
    has_next  = 1'b0;
    for (int w = c_nwords - 1; w >= 0; w--) begin
      if (grp_in[w]) begin
        first_idx = p_in_nbits'(w);
      end
      if (grp_reg[w] && (w > int'(idx))) begin
        next_idx = p_in_nbits'(w);
        has_next = 1'b1;
      end
    end
  end

  // Beat outputs come only from registered state; in_* never reaches out_*.
  assign out_val    = (state == st_send);
  assign out_offset = idx;
  assign out_data   = words[idx];
  assign out_wben   = mask_reg[{idx, 2'b00} +: 4];
  assign out_last   = out_val && !has_next;

`ifdef PLAB3_MEM_SER_BYPASS_EN
  assign in_rdy = (state == st_idle) || (out_rdy && out_last);
`else
  assign in_rdy = (state == st_idle);
`endif

  logic in_fire;
  logic out_fire;
  assign in_fire  = in_val && in_rdy;
  assign out_fire = out_val && out_rdy;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= st_idle;
      line_reg <= '0;
      mask_reg <= '0;
      idx      <= '0;
    end else begin
      if (out_fire) begin
        if (out_last) begin
          state    <= st_idle;
          mask_reg <= '0;
          idx      <= '0;
        end else begin
          idx <= next_idx;
        end
      end
      // Placed after the beat update so a line taken alongside the last beat
      // (bypass build) overrides the return to idle.
      if (in_fire) begin
        line_reg <= in_line;
        mask_reg <= in_wben;
        idx      <= first_idx;
        state    <= (|in_wben) ? st_send : st_idle;
      end
    end
  end

endmodule

// File: tb/tb_plab3_mem_line_serializer.sv
module tb_plab3_mem_line_serializer;

  logic         clk;
  logic         reset_n;
  logic         sd;
  logic         in_val;
  logic         in_rdy;
  logic [127:0] in_line;
  logic [15:0]  in_wben;
  logic         out_val;
  logic         out_rdy;
  logic [31:0]  out_data;
  logic [1:0]   out_offset;
  logic [3:0]   out_wben;
  logic         out_last;

  plab3_mem_line_serializer #(.p_in_nbits(2), .p_word_nbits(32)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sd         (sd),
    .in_val     (in_val),
    .in_rdy     (in_rdy),
    .in_line    (in_line),
    .in_wben    (in_wben),
    .out_val    (out_val),
    .out_rdy    (out_rdy),
    .out_data   (out_data),
    .out_offset (out_offset),
    .out_wben   (out_wben),
    .out_last   (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  off;
    logic [3:0]  wben;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  int    n_cmp = 0;
  int    n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: one beat per word with a nonzero enable group, last on the highest.
  task automatic push_exp(input logic [127:0] line, input logic [15:0] wben);
    int    hi;
    beat_t b;
    hi = -1;
    for (int w = 0; w < 4; w++) if (wben[4*w +: 4] != 4'h0) hi = w;
    for (int w = 0; w < 4; w++) begin
      if (wben[4*w +: 4] != 4'h0) begin
        b.data = line[32*w +: 32];
        b.off  = 2'(w);
        b.wben = wben[4*w +: 4];
        b.last = (w == hi);
        exp_q.push_back(b);
      end
    end
  endtask

  // Every visible beat is checked against the queue head, including stalled
  // cycles, so a beat that changes while held or is lost/duplicated shows up.
  always @(negedge clk) begin
    if (reset_n && out_val) begin
      if (exp_q.size() == 0) begin
        chk("extra_beat", 64'(out_val), 64'd0);
      end else begin
        chk("out_data",   64'(out_data),   64'(exp_q[0].data));
        chk("out_offset", 64'(out_offset), 64'(exp_q[0].off));
        chk("out_wben",   64'(out_wben),   64'(exp_q[0].wben));
        chk("out_last",   64'(out_last),   64'(exp_q[0].last));
        if (out_rdy) void'(exp_q.pop_front());
        else chk("stall_in_rdy", 64'(in_rdy), 64'd0);
      end
    end
  end

  // Present a line, wait (bounded) for acceptance, then check first-beat latency.
  task automatic put_line(input logic [127:0] line, input logic [15:0] wben);
    int t;
    t = 0;
    in_line = line;
    in_wben = wben;
    in_val  = 1'b1;
    while (!in_rdy && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    chk("in_rdy_seen", 64'(in_rdy), 64'd1);
    @(posedge clk);
    push_exp(line, wben);
    #1;
    in_val = 1'b0;
    if (wben != 16'h0) begin
      chk("first_beat_lat", 64'(out_val), 64'd1);
    end else begin
      chk("empty_out_val", 64'(out_val), 64'd0);
      chk("empty_in_rdy",  64'(in_rdy),  64'd1);
    end
  endtask

  // mode 0: out_rdy high; 1: pattern 1,0,0,1; 2: random. Returns cycles taken.
  task automatic drain(input int mode, output int n);
    logic [3:0] pat;
    pat = 4'b1001;
    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      if (mode == 1) out_rdy = pat[n % 4];
      else if (mode == 2) out_rdy = 1'($urandom_range(0, 1));
      else out_rdy = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    chk("drain_done", 64'(exp_q.size()), 64'd0);
    out_rdy = 1'b1;
  endtask

  logic [127:0] line_a;
  logic [127:0] line_b;
  int           cyc;

  initial begin
    reset_n = 1'b0;
    sd      = 1'b0;
    in_val  = 1'b0;
    in_line = '0;
    in_wben = '0;
    out_rdy = 1'b0;
    line_a  = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    line_b  = {32'hB3, 32'hB2, 32'hB1, 32'hB0};

    #3;
    chk("rst_out_val",    64'(out_val),    64'd0);
    chk("rst_in_rdy",     64'(in_rdy),     64'd1);
    chk("rst_out_offset", 64'(out_offset), 64'd0);
    chk("rst_out_last",   64'(out_last),   64'd0);
    chk("rst_out_data",   64'(out_data),   64'd0);
    chk("rst_out_wben",   64'(out_wben),   64'd0);
    @(posedge clk); #2;
    reset_n = 1'b1;
    @(posedge clk); #1;
    out_rdy = 1'b1;

    // Full mask, four beats on consecutive cycles
    put_line(line_a, 16'hFFFF);
    drain(0, cyc);
    chk("full_cycles", 64'(cyc), 64'd4);
    chk("idle_after_full", 64'(out_val), 64'd0);

    // Sparse masks
    put_line(line_a, 16'h0F00);
    drain(0, cyc);
    chk("sparse1_cycles", 64'(cyc), 64'd1);
    put_line(line_b, 16'h3001);
    drain(0, cyc);
    chk("sparse2_cycles", 64'(cyc), 64'd2);

    // Backpressure
    out_rdy = 1'b0;
    put_line(line_b, 16'hFFFF);
    drain(1, cyc);

    // Empty mask
    put_line(line_a, 16'h0000);
    @(posedge clk); #1;
    chk("empty_still_idle", 64'(out_val), 64'd0);

    // Random lines with random backpressure
    for (int i = 0; i < 8; i++) begin
      put_line({$urandom, $urandom, $urandom, $urandom}, 16'($urandom));
      drain(2, cyc);
    end

    // Abort: async reset after the second beat of a full line
    put_line(line_a, 16'hFFFF);
    @(posedge clk); #1;
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    chk("abort_out_val",    64'(out_val),    64'd0);
    chk("abort_in_rdy",     64'(in_rdy),     64'd1);
    chk("abort_out_offset", 64'(out_offset), 64'd0);
    chk("abort_out_wben",   64'(out_wben),   64'd0);
    exp_q.delete();
    #4;
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("abort_no_beat", 64'(out_val), 64'd0);
    end

    // Back-to-back lines
    put_line(line_a, 16'h00F0);
`ifdef PLAB3_MEM_SER_BYPASS_EN
    chk("bypass_in_rdy", 64'(in_rdy), 64'd1);
    put_line(line_b, 16'hF000);
    chk("bypass_offset", 64'(out_offset), 64'd3);
`else
    chk("no_bypass_in_rdy", 64'(in_rdy), 64'd0);
    @(posedge clk); #1;
    chk("bubble_out_val", 64'(out_val), 64'd0);
    put_line(line_b, 16'hF000);
    chk("second_offset", 64'(out_offset), 64'd3);
`endif
    drain(0, cyc);

    @(posedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
